uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `uart_tx` serializer between `REQ_NUM` byte requesters. It sits between client logic (register bank, debug streamer, DMA) and the transmitter. It latches one byte per grant, issues a one-cycle launch pulse to the transmitter, and holds the grant until the transmitter reports frame completion. A per-requester lock keeps back-to-back bytes together, and a watchdog recovers from a transmitter that never completes.

---
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART serializer between REQ_NUM byte requesters.
// One byte per grant, one-cycle launch pulse, grant held until frame completion or watchdog abort.
module uart_tx_arbiter #(
  parameter int unsigned DLY         = 1,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned REQ_NUM     = 4,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [REQ_NUM-1:0]            req_vld_i,
  input  logic [REQ_NUM*DATA_WIDTH-1:0] req_data_i,
  input  logic [REQ_NUM-1:0]            req_lock_i,
  output logic [REQ_NUM-1:0]            req_rdy_o,
  output logic [DATA_WIDTH-1:0]         tx_data_o,
  output logic                          tx_vld_o,
  input  logic                          tx_done_i,
  output logic [REQ_NUM-1:0]            grant_o,
  output logic                          busy_o,
  output logic                          err_o
);

  localparam int unsigned IdxW = $clog2(REQ_NUM);
  // DLY only models assignment delay in simulation; it has no role in the logic.
  localparam int unsigned TimeoutCyc = TIMEOUT_CYC + 0 * DLY;
  localparam logic [15:0] WdLast = (TimeoutCyc == 0) ? 16'd0 : 16'(TimeoutCyc - 1);

  typedef enum logic [2:0] {
    StIdle = 3'b001,
    StSend = 3'b010,
    StWait = 3'b100
  } state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         last_q, last_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_vld_q, tx_vld_d;
  logic [REQ_NUM-1:0]      req_rdy_q, req_rdy_d;
  logic [REQ_NUM-1:0]      grant_q, grant_d;
  logic                    err_q, err_d;
  logic [15:0]             wd_cnt_q, wd_cnt_d;

  logic [IdxW-1:0]         win_idx;
  logic [IdxW-1:0]         cand;
  logic                    win_hit;
  logic [REQ_NUM-1:0]      win_oh;
  logic [DATA_WIDTH-1:0]   win_data;
  logic                    wd_expire;

  // Winner: a locked, still-valid last owner keeps the grant; otherwise the first valid
  // requester after last, wrapping round to last itself.
  always_comb begin
    win_idx = last_q;
    cand    = '0;
    win_hit = 1'b0;
    if (req_lock_i[last_q] && req_vld_i[last_q]) begin
      win_hit = 1'b1;
    end else begin
      for (int unsigned i = 1; i <= REQ_NUM; i++) begin
        cand = IdxW'((32'(last_q) + i) % REQ_NUM);
        if (!win_hit && req_vld_i[cand]) begin
          win_hit = 1'b1;
          win_idx = cand;
        end
      end
    end
    win_oh          = '0;
    win_oh[win_idx] = 1'b1;
    win_data        = req_data_i[32'(win_idx) * DATA_WIDTH +: DATA_WIDTH];
  end

  assign wd_expire = (TimeoutCyc != 0) && (wd_cnt_q == WdLast);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    tx_data_d = tx_data_q;
    grant_d   = grant_q;
    wd_cnt_d  = wd_cnt_q;
    tx_vld_d  = 1'b0;
    req_rdy_d = '0;
    err_d     = 1'b0;
    case (state_q)
      StIdle: begin
        wd_cnt_d = '0;
        if (win_hit) begin
          tx_data_d = win_data;
          grant_d   = win_oh;
          req_rdy_d = win_oh;
          tx_vld_d  = 1'b1;
          last_d    = win_idx;
          state_d   = StSend;
        end
      end
      StSend: begin
        wd_cnt_d = '0;
        state_d  = StWait;
      end
      StWait: begin
        // A completion in the timeout cycle takes precedence over the abort.
        if (tx_done_i) begin
          state_d  = StIdle;
          grant_d  = '0;
          wd_cnt_d = '0;
        end else if (wd_expire) begin
          err_d    = 1'b1;
          state_d  = StIdle;
          grant_d  = '0;
          wd_cnt_d = '0;
        end else begin
          wd_cnt_d = wd_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d  = StIdle;
        grant_d  = '0;
        wd_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      last_q    <= IdxW'(REQ_NUM - 1);
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      req_rdy_q <= '0;
      grant_q   <= '0;
      err_q     <= 1'b0;
      wd_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      req_rdy_q <= req_rdy_d;
      grant_q   <= grant_d;
      err_q     <= err_d;
      wd_cnt_q  <= wd_cnt_d;
    end
  end

  assign req_rdy_o = req_rdy_q;
  assign tx_data_o = tx_data_q;
  assign tx_vld_o  = tx_vld_q;
  assign grant_o   = grant_q;
  assign err_o     = err_q;
  assign busy_o    = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed vector table, hand sequences for the
// multi-cycle corners, and randomized traffic against a transaction-level reference model.
module tb_uart_tx_arbiter;

  localparam int unsigned DW     = 8;
  localparam int unsigned N      = 4;
  localparam int unsigned T_MAIN = 24;
  localparam int unsigned T_WD   = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    req_vld, req_lock, req_rdy, grant;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0]   tx_data;
  logic            tx_vld, tx_done, busy, err;

  logic [N-1:0]    w_vld, w_lock, w_rdy, w_grant;
  logic [N*DW-1:0] w_data;
  logic [DW-1:0]   w_tx_data;
  logic            w_tx_vld, w_done, w_busy, w_err;

  uart_tx_arbiter #(
    .DLY        (1),
    .DATA_WIDTH (DW),
    .REQ_NUM    (N),
    .TIMEOUT_CYC(T_MAIN)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .req_vld_i (req_vld),
    .req_data_i(req_data),
    .req_lock_i(req_lock),
    .req_rdy_o (req_rdy),
    .tx_data_o (tx_data),
    .tx_vld_o  (tx_vld),
    .tx_done_i (tx_done),
    .grant_o   (grant),
    .busy_o    (busy),
    .err_o     (err)
  );

  uart_tx_arbiter #(
    .DLY        (1),
    .DATA_WIDTH (DW),
    .REQ_NUM    (N),
    .TIMEOUT_CYC(T_WD)
  ) dut_wd (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .req_vld_i (w_vld),
    .req_data_i(w_data),
    .req_lock_i(w_lock),
    .req_rdy_o (w_rdy),
    .tx_data_o (w_tx_data),
    .tx_vld_o  (w_tx_vld),
    .tx_done_i (w_done),
    .grant_o   (w_grant),
    .busy_o    (w_busy),
    .err_o     (w_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [N-1:0] vld;
    logic [N-1:0] lock;
    logic [N-1:0] exp_grant;
  } vec_t;

  vec_t vecs[15];

  // Reference arbitration: locked valid last owner wins, else the valid requester at the
  // smallest rotational distance after last.
  function automatic int pick(input logic [N-1:0] v, input logic [N-1:0] l, input int last);
    int best, bestd, d;
    best  = -1;
    bestd = N;
    if (v[last] && l[last]) return last;
    for (int k = 0; k < N; k++) begin
      d = (k - last - 1 + 2 * N) % N;
      if (v[k] && d < bestd) begin
        bestd = d;
        best  = k;
      end
    end
    return best;
  endfunction

  function automatic int oh2idx(input logic [N-1:0] oh);
    for (int k = 0; k < N; k++) if (oh[k]) return k;
    return 0;
  endfunction

  // Model state for the random phase: 0 idle, 1 launch cycle, 2 waiting for completion.
  int             m_phase, m_owner, m_last, m_age;
  logic [DW-1:0]  m_data;
  logic           m_err;
  logic [N-1:0]   m_oh;

  initial begin
    int idx;
    vecs[0]  = '{4'b1111, 4'b0000, 4'b0001};
    vecs[1]  = '{4'b1111, 4'b0000, 4'b0010};
    vecs[2]  = '{4'b1111, 4'b0000, 4'b0100};
    vecs[3]  = '{4'b1111, 4'b0000, 4'b1000};
    vecs[4]  = '{4'b1111, 4'b0000, 4'b0001};
    vecs[5]  = '{4'b1111, 4'b0010, 4'b0010};
    vecs[6]  = '{4'b1111, 4'b0010, 4'b0010};
    vecs[7]  = '{4'b1111, 4'b0010, 4'b0010};
    vecs[8]  = '{4'b1111, 4'b0000, 4'b0100};
    vecs[9]  = '{4'b1010, 4'b0000, 4'b1000};
    vecs[10] = '{4'b1010, 4'b1000, 4'b1000};
    vecs[11] = '{4'b0010, 4'b1000, 4'b0010};
    vecs[12] = '{4'b0101, 4'b0001, 4'b0100};
    vecs[13] = '{4'b0001, 4'b0000, 4'b0001};
    vecs[14] = '{4'b0001, 4'b0000, 4'b0001};

    rst_n = 1'b0;
    req_vld = '0; req_lock = '0; tx_done = 1'b0;
    w_vld = '0; w_lock = '0; w_done = 1'b0;
    for (int k = 0; k < N; k++) begin
      req_data[k*DW +: DW] = DW'(8'h10 + k);
      w_data[k*DW +: DW]   = DW'(8'h20 + k);
    end

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", {tx_data, tx_vld, req_rdy, grant, busy, err}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {tx_vld, grant, busy, err}, '0);

    // Round-robin fairness and lock behaviour; done 10 cycles after each launch
    for (int r = 0; r < 15; r++) begin
      req_vld  = vecs[r].vld;
      req_lock = vecs[r].lock;
      @(negedge clk);
      idx = oh2idx(vecs[r].exp_grant);
      chk($sformatf("vec%0d_launch", r), {tx_vld, busy}, 2'b11);
      chk($sformatf("vec%0d_grant", r), grant, vecs[r].exp_grant);
      chk($sformatf("vec%0d_rdy", r), req_rdy, vecs[r].exp_grant);
      chk($sformatf("vec%0d_data", r), tx_data, 64'(8'h10 + idx));
      @(negedge clk);
      chk($sformatf("vec%0d_pulse_end", r), {tx_vld, req_rdy}, '0);
      repeat (8) @(negedge clk);
      @(negedge clk);
      tx_done = 1'b1;
      chk($sformatf("vec%0d_busy_hold", r), {busy, grant}, {1'b1, vecs[r].exp_grant});
      @(negedge clk);
      tx_done = 1'b0;
      chk($sformatf("vec%0d_idle", r), {busy, grant, err}, '0);
      chk($sformatf("vec%0d_data_hold", r), tx_data, 64'(8'h10 + idx));
    end
    req_vld  = '0;
    req_lock = '0;

    // Single request: requester 2, 0xA5, done 20 cycles after launch
    @(negedge clk);
    req_data[2*DW +: DW] = 8'hA5;
    req_vld = 4'b0100;
    @(negedge clk);
    chk("single_launch", {tx_vld, tx_data, grant, req_rdy}, {1'b1, 8'hA5, 4'b0100, 4'b0100});
    req_vld = '0;
    repeat (19) @(negedge clk);
    @(negedge clk);
    tx_done = 1'b1;
    chk("single_busy_at_done", busy, 1'b1);
    @(negedge clk);
    tx_done = 1'b0;
    chk("single_busy_fall", {busy, grant}, '0);

    // Spurious done in IDLE, then in the launch cycle
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("spur_idle", {busy, grant, tx_vld, err}, '0);
    req_vld = 4'b0001;
    tx_done = 1'b1;
    @(negedge clk);
    chk("spur_idle_launch", {tx_vld, busy, grant}, {1'b1, 1'b1, 4'b0001});
    req_vld = '0;
    @(negedge clk);
    tx_done = 1'b0;
    chk("spur_send_ignored", {busy, grant}, {1'b1, 4'b0001});
    repeat (3) @(negedge clk);
    chk("spur_still_busy", busy, 1'b1);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("spur_real_done", {busy, grant}, '0);

    // Reset mid-transfer: last is 0, so without reset 0|3 would grant 3
    req_vld = 4'b0001;
    @(negedge clk);
    chk("rst_pre_launch", grant, 4'b0001);
    req_vld = '0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_clear", {tx_data, tx_vld, req_rdy, grant, busy, err}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    req_vld = 4'b1001;
    @(negedge clk);
    chk("rst_first_prio", {grant, tx_data}, {4'b0001, 8'h10});
    req_vld = '0;
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("rst_recover_idle", busy, 1'b0);

    // Watchdog, T=8: abort 9 cycles after launch
    w_vld = 4'b0010;
    @(negedge clk);
    chk("wd_launch", {w_tx_vld, w_grant}, {1'b1, 4'b0010});
    w_vld = '0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c < 9) begin
        chk($sformatf("wd_no_err_c%0d", c), {w_err, w_busy}, 2'b01);
      end else begin
        chk("wd_err_pulse", w_err, 1'b1);
        chk("wd_grant_clear", w_grant, '0);
      end
    end
    w_vld = 4'b0100;
    @(negedge clk);
    chk("wd_err_one_cycle", w_err, 1'b0);
    chk("wd_next_served", {w_tx_vld, w_grant, w_tx_data}, {1'b1, 4'b0100, 8'h22});
    w_vld = '0;
    repeat (7) @(negedge clk);
    @(negedge clk);
    w_done = 1'b1;
    @(negedge clk);
    w_done = 1'b0;
    chk("wd_done_wins", {w_err, w_busy, w_grant}, '0);
    @(negedge clk);
    chk("wd_done_wins_after", w_err, 1'b0);

    // Randomized traffic against the reference model
    rst_n = 1'b0;
    req_vld = '0; req_lock = '0; tx_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_phase = 0; m_owner = 0; m_last = N - 1; m_age = 0; m_data = '0; m_err = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      m_oh = (m_phase != 0) ? N'(1 << m_owner) : '0;
      chk("rand_outputs", {grant, req_rdy, tx_vld, busy, err, tx_data},
          {m_oh, (m_phase == 1) ? m_oh : 4'b0000, m_phase == 1, m_phase != 0, m_err, m_data});
      for (int k = 0; k < N; k++) begin
        if (m_phase == 1 && k == m_owner) begin
          req_vld[k] = ($urandom_range(0, 1) == 0);
          req_data[k*DW +: DW] = DW'($urandom);
        end else if (!req_vld[k] && $urandom_range(0, 3) == 0) begin
          req_vld[k] = 1'b1;
          req_data[k*DW +: DW] = DW'($urandom);
        end
        req_lock[k] = ($urandom_range(0, 2) == 0);
      end
      tx_done = (m_phase == 2) ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 7) == 0);
      m_err = 1'b0;
      case (m_phase)
        0: if (|req_vld) begin
          m_owner = pick(req_vld, req_lock, m_last);
          m_last  = m_owner;
          m_data  = req_data[m_owner*DW +: DW];
          m_phase = 1;
        end
        1: begin
          m_phase = 2;
          m_age   = 1;
        end
        default: begin
          if (tx_done) begin
            m_phase = 0;
          end else if (m_age == int'(T_MAIN)) begin
            m_err   = 1'b1;
            m_phase = 0;
          end else begin
            m_age++;
          end
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
